// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, credit-limited requests to imem, prefetch FIFO to decode.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_unit #(
  parameter int              DW       = 32,
  parameter int              AW       = 32,
  parameter int              DEPTH    = 4,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_out,
  output logic [AW-1:0] pc_out,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_fetch_pc;
  logic [DW-1:0] r_fifo_data [DEPTH];
  logic [AW-1:0] r_fifo_pc   [DEPTH];
  logic [AW-1:0] r_tag_pc    [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_tag_wr, r_tag_rd;
  logic [CW-1:0] r_count, r_outstanding, r_drop_cnt;

  logic [CW:0]   w_credit_sum;
  logic          w_issue_ok;
  logic          w_head_valid;
  logic          w_keep;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_resp_pc;
  logic [AW-1:0] w_redirect_aligned;

  assign w_credit_sum       = {1'b0, r_count} + {1'b0, r_outstanding};
  // Gating with rst keeps the request low for the whole reset window.
  assign w_issue_ok         = rst && (w_credit_sum < (CW+1)'(DEPTH)) && (r_drop_cnt == '0);
  assign imem_req           = w_issue_ok && !redirect;
  assign imem_addr          = r_fetch_pc;
  assign w_head_valid       = (r_count != '0);
  assign w_resp_pc          = r_tag_pc[r_tag_rd];
  assign w_keep             = rst && imem_rvalid && (r_drop_cnt == '0) && !redirect;
  assign w_pop              = w_head_valid && instr_ready;
  assign w_redirect_aligned = redirect_pc & ~AW'(3);

`ifdef FETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = !w_head_valid && w_keep;
  assign instr_valid = w_head_valid || w_bypass;
  assign instr_out   = w_bypass ? imem_rdata : (w_head_valid ? r_fifo_data[r_rd_ptr] : '0);
  assign pc_out      = w_bypass ? w_resp_pc  : (w_head_valid ? r_fifo_pc[r_rd_ptr]   : '0);
  assign w_push      = w_keep && !(w_bypass && instr_ready);
`else
  assign instr_valid = w_head_valid;
  assign instr_out   = w_head_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign pc_out      = w_head_valid ? r_fifo_pc[r_rd_ptr]   : '0;
  assign w_push      = w_keep;
`endif

  always_ff @(posedge clk) begin
    if (imem_req) r_tag_pc[r_tag_wr] <= r_fetch_pc;
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= w_resp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (imem_req)    r_tag_wr <= r_tag_wr + 1'b1;
      if (imem_rvalid) r_tag_rd <= r_tag_rd + 1'b1;
      r_outstanding <= r_outstanding + CW'(imem_req) - CW'(imem_rvalid);
      if (redirect) begin
        // Everything still in flight, minus a response landing now, is stale.
        r_fetch_pc <= w_redirect_aligned;
        r_drop_cnt <= r_outstanding - CW'(imem_rvalid);
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (imem_req) r_fetch_pc <= r_fetch_pc + AW'(4);
        if (imem_rvalid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - 1'b1;
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model feeds responses, monitor checks every visible head.
module tb_fetch_unit;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] pc_out;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;

  fetch_unit #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .pc_out(pc_out),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { int unsigned due; logic [31:0] data; } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  logic [31:0] req_log[$];
  int unsigned cyc = 0;
  int unsigned req_cnt = 0;
  int unsigned pop_cnt = 0;
  int unsigned lat = 1;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'h00500080;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = start + 32'(4 * i);
      e.data = mem_fn(e.pc);
      exp_q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory: request seen before edge 'up' is answered for edge 'up+lat', in order.
  initial forever begin
    int unsigned up;
    mreq_t m;
    @(negedge clk);
    up = cyc + 1;
    if (mem_q.size() > 0 && mem_q[0].due == up) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    if (rst && imem_req) begin
      m.due  = up + lat;
      m.data = mem_fn(imem_addr);
      mem_q.push_back(m);
      req_log.push_back(imem_addr);
      req_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (rst && instr_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_instr: got pc 0x%0h expected no instruction", pc_out);
      end else begin
        check("head_pc", 64'(pc_out), 64'(exp_q[0].pc));
        check("head_data", 64'(instr_out), 64'(exp_q[0].data));
        if (instr_ready) begin
          void'(exp_q.pop_front());
          pop_cnt++;
        end
      end
    end
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned p0, r0;
    bit found;

    // Reset state
    #1 rst = 1'b0;
    #1;
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr_out), 64'd0);
    check("rst_pc", 64'(pc_out), 64'd0);

    // 1-cycle memory, ready=1
    lat = 1;
    instr_ready = 1'b1;
    push_stream(32'h0, 200);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    check("first_resp_rvalid", 64'(imem_rvalid), 64'd1);
`ifdef FETCH_BYPASS_EN
    check("bypass_valid", 64'(instr_valid), 64'd1);
    check("bypass_data", 64'(instr_out), 64'h00500093);
    check("bypass_pc", 64'(pc_out), 64'd0);
`else
    check("fifo_latency_valid", 64'(instr_valid), 64'd0);
`endif
    repeat (4) @(posedge clk);
    #1 p0 = pop_cnt;
    repeat (8) @(posedge clk);
    #1;
    check("one_per_cycle", 64'(pop_cnt - p0), 64'd8);
    for (int i = 0; i < 5; i++)
      check("addr_seq", 64'(req_log.size() > i ? req_log[i] : 32'hDEADBEEF), 64'(4 * i));

    // Credit limit with decode stalled
    rst = 1'b0;
    mem_q.delete(); exp_q.delete(); req_log.delete();
    instr_ready = 1'b0;
    @(posedge clk);
    #1;
    push_stream(32'h0, 200);
    r0 = req_cnt;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("credit_req_count", 64'(req_cnt - r0), 64'd4);
    check("credit_req_low", 64'(imem_req), 64'd0);
    check("credit_valid", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    p0 = pop_cnt;
    repeat (4) @(posedge clk);
    #1;
    check("drain_count", 64'(pop_cnt - p0), 64'd4);

    // 3-cycle memory, redirect with two requests in flight
    rst = 1'b0;
    mem_q.delete(); exp_q.delete(); req_log.delete();
    lat = 3;
    @(posedge clk);
    #1;
    push_stream(32'h0, 200);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    exp_q.delete();
    push_stream(32'h100, 200);
    check("redir_valid_low", 64'(instr_valid), 64'd0);
    p0 = pop_cnt;
    repeat (12) @(posedge clk);
    #1;
    check("redir_progress", 64'(pop_cnt - p0 >= 4), 64'd1);

    // Redirect coinciding with a response; low PC bits must be cleared
    rst = 1'b0;
    mem_q.delete(); exp_q.delete(); req_log.delete();
    lat = 2;
    @(posedge clk);
    #1;
    push_stream(32'h0, 200);
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due == cyc + 1) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("redir_rvalid_found", 64'(found), 64'd1);
    redirect = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clk);
    #2;
    check("redir_same_cycle_rvalid", 64'(imem_rvalid), 64'd1);
    check("redir_no_req", 64'(imem_req), 64'd0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    exp_q.delete();
    push_stream(32'h200, 200);
    p0 = pop_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("redir2_progress", 64'(pop_cnt - p0 >= 4), 64'd1);

    // Reset mid-stream with three outstanding
    rst = 1'b0;
    mem_q.delete(); exp_q.delete(); req_log.delete();
    lat = 3;
    instr_ready = 1'b0;
    @(posedge clk);
    #1;
    push_stream(32'h0, 200);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_valid", 64'(instr_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_req", 64'(imem_req), 64'd0);
    check("midrst_valid", 64'(instr_valid), 64'd0);
    check("midrst_instr", 64'(instr_out), 64'd0);
    check("midrst_pc", 64'(pc_out), 64'd0);
    mem_q.delete(); exp_q.delete(); req_log.delete();
    repeat (2) @(posedge clk);
    #1;
    push_stream(32'h0, 200);
    lat = 1;
    instr_ready = 1'b1;
    rst = 1'b1;
    p0 = pop_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("restart_progress", 64'(pop_cnt - p0 >= 8), 64'd1);
    check("restart_addr", 64'(req_log.size() > 0 ? req_log[0] : 32'hDEADBEEF), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction fetch stage; successor to the single-cycle PC + instruction ROM path.
- Owns the program counter and issues in-order requests to a variable-latency instruction memory.
- Buffers returned instructions with their PCs in a DEPTH-entry prefetch FIFO.
- Presents instructions to decode on a valid/ready handshake; a branch/jump redirect flushes the pipeline.

Parameters:
- DW, 32, instruction/data width
- AW, 32, address/PC width
- DEPTH, 4, prefetch FIFO entries and max in-flight requests; power of two, >= 2
- RESET_PC, 0, PC fetched first after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low (rst=0 resets)
- imem_req  out  1  request valid; memory accepts every asserted request
- imem_addr  out  AW  request address
- imem_rvalid  in  1  response valid; responses return in order, latency >= 1 cycle
- imem_rdata  in  DW  response instruction
- instr_valid  out  1  FIFO head valid
- instr_ready  in  1  decode accepts head
- instr_out  out  DW  head instruction
- pc_out  out  AW  PC of head instruction
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  AW  new PC (PC + ImmOp from execute)

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0
  - imem_req=0, instr_valid=0, instr_out=0, pc_out=0
- Credit rule: issue allowed when occupancy + outstanding < DEPTH and drop_cnt == 0.
- imem_req = issue allowed and redirect=0 (combinational); imem_addr = fetch_pc.
- First imem_req occurs in the first cycle after rst deasserts, with addr=RESET_PC.
- Each issued request: fetch_pc += 4 (wraps modulo 2^AW); outstanding += 1.
- Each imem_rvalid: outstanding -= 1.
  - If drop_cnt > 0: drop_cnt -= 1 and the data is discarded.
  - Otherwise {imem_rdata, PC of that request} is pushed to the FIFO.
  - Request PCs are tracked in a DEPTH-entry tag queue.
- Pop when instr_valid && instr_ready; FIFO latency is 1 cycle (push -> visible the next cycle).
- Simultaneous push and pop when full is legal; the credit rule guarantees no overflow.
- Push into an empty FIFO with ready=1 still takes 1 cycle (base build).
- redirect=1 takes priority over everything in that cycle:
  - FIFO cleared; instr_valid=0 the next cycle; no request issued that cycle.
  - fetch_pc <= redirect_pc.
  - drop_cnt <= outstanding minus 1 if imem_rvalid is high in the same cycle (that response is discarded).
  - A pop in the redirect cycle is honoured (decode consumed it).
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Issue resumes in the cycle after drop_cnt reaches 0.
- Bits [1:0] of redirect_pc are forced to 0.
- An imem_rvalid with outstanding=0 is illegal; the simulation assertion fires.

Optional Feature:
- Macro: FETCH_BYPASS_EN
- Defined:
  - When the FIFO is empty, drop_cnt=0, redirect=0 and imem_rvalid=1, instr_valid/instr_out/pc_out are driven combinationally from the response in the same cycle.
  - If instr_ready=1, the entry is consumed without being written to the FIFO; otherwise it is pushed normally.
- Undefined: 1-cycle FIFO latency as above; no combinational path from imem_rdata to instr_out.

Test Plan:
- Reset, 1-cycle memory, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8…; pc_out follows one cycle after each response, one instruction per cycle.
- instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, then imem_req=0; on ready=1, 4 instructions drain in order with PCs 0x0–0xC.
- 3-cycle latency, redirect to 0x100 with 2 outstanding -> both stale responses dropped; first instr_out has pc_out=0x100; no stale PC ever visible.
- Redirect to 0x200 in the same cycle as imem_rvalid -> that response is discarded, drop_cnt counts correctly, next valid pc_out=0x200.
- rst asserted mid-stream with 3 outstanding -> outputs zero immediately; after release, fetch restarts at RESET_PC; late responses are ignored by the bench.
- FETCH_BYPASS_EN, empty FIFO, 1-cycle memory, ready=1 -> instr_valid in the same cycle as imem_rvalid, data 0x00500093 at pc_out 0x0.
